// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: accepts one (a, b) bit pair per beat and registers
// greater/equal/less once WIDTH beats have arrived.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  output logic in_ready,
  output logic busy,
  output logic done,
  output logic g,
  output logic e,
  output logic l
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wg_q, wg_d;
  logic            wl_q, wl_d;
  logic            g_q, g_d;
  logic            e_q, e_d;
  logic            l_q, l_d;

  logic beat;
  logic wg_nxt, wl_nxt;

  assign beat = in_valid && (state_q == StCompare);

  // Working flags including the current beat, so the final beat is reflected in the result.
  always_comb begin
    wg_nxt = wg_q;
    wl_nxt = wl_q;
    if (MSB_FIRST) begin
      if (!wg_q && !wl_q) begin
        wg_nxt = a & ~b;
        wl_nxt = ~a & b;
      end
    end else if (a != b) begin
      wg_nxt = a;
      wl_nxt = b;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wg_d    = wg_q;
    wl_d    = wl_q;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCompare;
          cnt_d   = '0;
          wg_d    = 1'b0;
          wl_d    = 1'b0;
        end
      end
      StCompare: begin
        if (beat) begin
          cnt_d = cnt_q + CntW'(1);
          wg_d  = wg_nxt;
          wl_d  = wl_nxt;
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            g_d     = wg_nxt;
            l_d     = wl_nxt;
            e_d     = ~wg_nxt & ~wl_nxt;
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d = StCompare;
          cnt_d   = '0;
          wg_d    = 1'b0;
          wl_d    = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wg_q    <= 1'b0;
      wl_q    <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wg_q    <= wg_d;
      wl_q    <= wl_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
    end
  end

  assign in_ready = (state_q == StCompare);
  assign busy     = (state_q == StCompare);
  assign done     = (state_q == StDone);
  assign g        = g_q;
  assign e        = e_q;
  assign l        = l_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three instances (4-bit MSB-first, 4-bit LSB-first,
// 1-bit) checked every cycle against a word-level arithmetic model, plus literal expectations.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] in_valid_v = '0;
  logic [2:0] a_v = '0;
  logic [2:0] b_v = '0;
  logic [2:0] in_ready_v, busy_v, done_v, g_v, e_v, l_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid_v[0]), .a(a_v[0]),
    .b(b_v[0]), .in_ready(in_ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .g(g_v[0]),
    .e(e_v[0]), .l(l_v[0])
  );

  serial_magnitude_comparator #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid_v[1]), .a(a_v[1]),
    .b(b_v[1]), .in_ready(in_ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .g(g_v[1]),
    .e(e_v[1]), .l(l_v[1])
  );

  serial_magnitude_comparator #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid_v[2]), .a(a_v[2]),
    .b(b_v[2]), .in_ready(in_ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .g(g_v[2]),
    .e(e_v[2]), .l(l_v[2])
  );

  // Word-level model: collect bits into integers, compare arithmetically when the word is full.
  int m_width[3] = '{4, 4, 1};
  bit m_msb[3]   = '{1'b1, 1'b0, 1'b1};
  int m_st[3]    = '{0, 0, 0};  // 0 idle, 1 comparing, 2 result cycle
  int m_cnt[3]   = '{0, 0, 0};
  int m_wa[3]    = '{0, 0, 0};
  int m_wb[3]    = '{0, 0, 0};
  bit m_g[3]     = '{1'b0, 1'b0, 1'b0};
  bit m_e[3]     = '{1'b0, 1'b0, 1'b0};
  bit m_l[3]     = '{1'b0, 1'b0, 1'b0};

  function automatic logic [5:0] outs(int k);
    return {in_ready_v[k], busy_v[k], done_v[k], g_v[k], e_v[k], l_v[k]};
  endfunction

  function automatic logic [5:0] model_outs(int k);
    return {m_st[k] == 1, m_st[k] == 1, m_st[k] == 2, m_g[k], m_e[k], m_l[k]};
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (outs(k) !== model_outs(k)) begin
          n_err++;
          $display("FAIL model_cmp dut%0d t=%0t: got rdy/busy/done/g/e/l=%b want %b",
                   k, $time, outs(k), model_outs(k));
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          m_st[k] = 0; m_cnt[k] = 0; m_g[k] = 0; m_e[k] = 0; m_l[k] = 0;
        end else begin
          case (m_st[k])
            0: if (start_v[k]) begin m_st[k] = 1; m_cnt[k] = 0; m_wa[k] = 0; m_wb[k] = 0; end
            1: if (in_valid_v[k]) begin
              if (m_msb[k]) begin
                m_wa[k] = (m_wa[k] << 1) | int'(a_v[k]);
                m_wb[k] = (m_wb[k] << 1) | int'(b_v[k]);
              end else begin
                m_wa[k] = m_wa[k] | (int'(a_v[k]) << m_cnt[k]);
                m_wb[k] = m_wb[k] | (int'(b_v[k]) << m_cnt[k]);
              end
              m_cnt[k]++;
              if (m_cnt[k] == m_width[k]) begin
                m_g[k]  = m_wa[k] > m_wb[k];
                m_e[k]  = m_wa[k] == m_wb[k];
                m_l[k]  = m_wa[k] < m_wb[k];
                m_st[k] = 2;
              end
            end
            default: begin
              if (start_v[k]) begin m_st[k] = 1; m_cnt[k] = 0; m_wa[k] = 0; m_wb[k] = 0; end
              else m_st[k] = 0;
            end
          endcase
        end
      end
    end
  end

  task automatic chk(string nm, logic [5:0] act, logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/busy/done/g/e/l=%b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(int k);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
  endtask

  task automatic beat(int k, logic av, logic bv, logic hold);
    in_valid_v[k] = 1'b1;
    a_v[k]        = av;
    b_v[k]        = bv;
    start_v[k]    = hold;
    tick();
    in_valid_v[k] = 1'b0;
  endtask

  task automatic beats(int k, int w, bit msb, int av, int bv, int gap, logic hold);
    for (int i = 0; i < w; i++) begin
      int idx;
      idx = msb ? (w - 1 - i) : i;
      beat(k, av[idx], bv[idx], hold);
      if (i < w - 1) repeat (gap) tick();
    end
    start_v[k] = 1'b0;
  endtask

  // Leaves the bench in the done cycle of the word, with the literal result checked.
  task automatic word(string nm, int k, int av, int bv, int gap, logic hold, logic [5:0] exp);
    start_word(k);
    beats(k, m_width[k], m_msb[k], av, bv, gap, hold);
    chk(nm, outs(k), exp);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk("reset_state", outs(k), 6'b000000);

    word("w4msb_gt", 0, 4'b1010, 4'b1001, 0, 1'b0, 6'b001100);
    tick();
    word("w4msb_lt_first_bit", 0, 4'b0111, 4'b1000, 0, 1'b0, 6'b001001);
    word("w4msb_eq", 0, 4'b0110, 4'b0110, 0, 1'b0, 6'b001010);
    repeat (2) tick();

    word("w4lsb_gt", 1, 4'b1010, 4'b1001, 0, 1'b0, 6'b001100);
    tick();
    word("w4lsb_lt", 1, 4'b0001, 4'b1000, 0, 1'b0, 6'b001001);
    repeat (2) tick();

    word("w4msb_stall", 0, 4'b1010, 4'b1001, 3, 1'b0, 6'b001100);
    tick();
    word("w4msb_start_held", 0, 4'b0011, 4'b0101, 0, 1'b1, 6'b001001);
    start_word(0);
    chk("b2b_busy", outs(0), 6'b110001);
    beats(0, 4, 1'b1, 4'b1100, 4'b1100, 0, 1'b0);
    chk("b2b_eq", outs(0), 6'b001010);
    tick();

    start_word(0);
    beat(0, 1'b1, 1'b0, 1'b0);
    beat(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset", outs(0), 6'b000000);
    word("after_reset_gt", 0, 4'b1100, 4'b1011, 0, 1'b0, 6'b001100);
    repeat (2) tick();

    word("w1_00", 2, 0, 0, 0, 1'b0, 6'b001010);
    word("w1_10", 2, 1, 0, 0, 1'b0, 6'b001100);
    tick();
    word("w1_01", 2, 0, 1, 0, 1'b0, 6'b001001);
    word("w1_11", 2, 1, 1, 0, 1'b0, 6'b001010);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
